// File: rtl/tb_pattern_chk.sv
// -----------------------------------------------------------------------------
// tb_pattern_chk
//
// Receive-side checker for the SFP link test pattern. The transmitter sends an
// 8-bit value that is held for 2**LSB_POS cycles and then increments modulo
// 256. This block locks onto the received stream and checks every value
// transition for the correct next value and the correct run length. It also
// flags a stream that stops changing. Lock status, a one-cycle error pulse and
// two saturating event counters are exported for a debug register block.
//
// Ports
//   i_clk      : system clock, all state changes on its rising edge
//   i_res      : synchronous active-high reset, highest priority
//   i_ptn      : received pattern byte, already synchronous to i_clk
//   i_clr_cnt  : synchronous clear of o_err_cnt and o_good_cnt
//   o_lock     : high while the checker is in LOCKED
//   o_err      : one-cycle pulse per detected error event
//   o_err_cnt  : saturating count of error events (SYNC and LOCKED only)
//   o_good_cnt : saturating count of good transitions (SYNC and LOCKED only)
//
// Latency: a bad value first present on i_ptn in cycle N raises o_err in
// cycle N+2. A stuck run raises o_err in the same cycle that a run ending at
// the stuck limit would have.
// -----------------------------------------------------------------------------
module tb_pattern_chk #(
  parameter int unsigned LSB_POS    = 10, // log2 of the nominal run length
  parameter int unsigned TOL        = 2,  // allowed run-length deviation, cycles
  parameter int unsigned LOCK_CNT   = 4,  // good transitions in SYNC to lock
  parameter int unsigned UNLOCK_ERR = 4   // consecutive errors in LOCKED to unlock
) (
  input  logic        i_clk,
  input  logic        i_res,
  input  logic [7:0]  i_ptn,
  input  logic        i_clr_cnt,
  output logic        o_lock,
  output logic        o_err,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_good_cnt
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Two spare bits let the run counter measure up to 4x the nominal run before
  // saturating, well beyond the stuck limit.
  localparam int unsigned RUN_W   = LSB_POS + 2;
  localparam int unsigned RUN_NOM = 1 << LSB_POS;

  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MIN   = RUN_W'(RUN_NOM - TOL);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(RUN_NOM + TOL);
  localparam logic [RUN_W-1:0] RUN_STUCK = RUN_W'(RUN_NOM + TOL + 1);
  localparam logic [RUN_W-1:0] RUN_SAT   = '1;

  localparam int unsigned GR_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BR_W = $clog2(UNLOCK_ERR + 1);

  localparam logic [GR_W-1:0] GOOD_ONE  = GR_W'(1);
  localparam logic [GR_W-1:0] GOOD_LAST = GR_W'(LOCK_CNT - 1);
  localparam logic [BR_W-1:0] BAD_ONE   = BR_W'(1);
  localparam logic [BR_W-1:0] BAD_LAST  = BR_W'(UNLOCK_ERR - 1);

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0, // waiting for the first value change, no checking
    ST_SYNC   = 2'd1, // checking, collecting good transitions towards lock
    ST_LOCKED = 2'd2  // checking, counting consecutive errors towards unlock
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [GR_W-1:0]  r_good_run;  // consecutive good transitions in SYNC
  logic [BR_W-1:0]  r_bad_run;   // consecutive error events in LOCKED

  logic [7:0]       r_ptn;       // registered input
  logic [7:0]       r_cur;       // value of the run currently being measured
  logic [RUN_W-1:0] r_run;       // cycles r_cur has been held so far
  logic             r_stuck;     // stuck error already raised for this run

  logic             r_err;
  logic [15:0]      r_err_cnt;
  logic [15:0]      r_good_cnt;

  // ---------------------------------------------------------------------------
  // Combinational event decode
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [GR_W-1:0]  w_good_run_nxt;
  logic [BR_W-1:0]  w_bad_run_nxt;

  logic [7:0]       w_cur_inc;
  logic             w_change;
  logic             w_checking;
  logic             w_val_ok;
  logic             w_run_ok;
  logic             w_stuck_hit;
  logic             w_good_evt;
  logic             w_err_evt;

  // The 8-bit sum wraps naturally, so 0xFF -> 0x00 is a legal step.
  assign w_cur_inc   = r_cur + 8'd1;
  assign w_change    = (r_ptn != r_cur);
  assign w_checking  = (r_state != ST_HUNT);
  assign w_val_ok    = (r_ptn == w_cur_inc);

  // Once a stuck error has been raised the run length is already known to be
  // bad; skipping the timing check keeps that run to a single error event.
  assign w_run_ok    = r_stuck || ((r_run >= RUN_MIN) && (r_run <= RUN_MAX));

  // A change in the same cycle wins: the run is then judged by the timing
  // check, so a run ending exactly at the limit still gives one event.
  assign w_stuck_hit = !w_change && !r_stuck && (r_run == RUN_STUCK);

  // Value and timing faults on one transition collapse into a single event.
  assign w_good_evt  = w_checking && w_change && w_val_ok && w_run_ok;
  assign w_err_evt   = w_checking &&
                       ((w_change && !(w_val_ok && w_run_ok)) || w_stuck_hit);

  // ---------------------------------------------------------------------------
  // Input capture and run-length tracking
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register,
  // independent of process ordering in simulation.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_ptn   <= 8'd0;
      r_cur   <= 8'd0;
      r_run   <= RUN_ONE;
      r_stuck <= 1'b0;
    end else begin
      r_ptn <= i_ptn;
      if (w_change) begin
        r_cur   <= r_ptn;
        r_run   <= RUN_ONE;
        r_stuck <= 1'b0;
      end else begin
        if (r_run != RUN_SAT) begin
          r_run <= r_run + RUN_ONE;
        end
        if (w_checking && w_stuck_hit) begin
          r_stuck <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state    <= ST_HUNT;
      r_good_run <= '0;
      r_bad_run  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_run <= w_good_run_nxt;
      r_bad_run  <= w_bad_run_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_good_run_nxt = r_good_run;
    w_bad_run_nxt  = r_bad_run;

    case (r_state)
      ST_HUNT: begin
        // The run that starts at this change is the first one that can be
        // measured from its beginning, so checking starts from here.
        if (w_change) begin
          w_state_nxt    = ST_SYNC;
          w_good_run_nxt = '0;
          w_bad_run_nxt  = '0;
        end
      end

      ST_SYNC: begin
        if (w_good_evt) begin
          w_good_run_nxt = r_good_run + GOOD_ONE;
          if (r_good_run == GOOD_LAST) begin
            w_state_nxt = ST_LOCKED;
          end
        end else if (w_err_evt) begin
          w_good_run_nxt = '0;
        end
      end

      ST_LOCKED: begin
        if (w_good_evt) begin
          w_bad_run_nxt = '0;
        end else if (w_err_evt) begin
          w_bad_run_nxt = r_bad_run + BAD_ONE;
          if (r_bad_run == BAD_LAST) begin
            w_state_nxt = ST_HUNT;
          end
        end
      end

      default: begin
        // Unreachable encoding: recover by re-acquiring the stream.
        w_state_nxt    = ST_HUNT;
        w_good_run_nxt = '0;
        w_bad_run_nxt  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  // Decoded from the state register, so o_lock changes on the same edge as
  // the state transition.
  always_comb begin
    o_lock = (r_state == ST_LOCKED);
  end

  // ---------------------------------------------------------------------------
  // Error pulse and saturating event counters
  // ---------------------------------------------------------------------------
  // w_err_evt and w_good_evt are already gated to SYNC/LOCKED. The clear wins
  // over a simultaneous increment but never suppresses the o_err pulse.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_err      <= 1'b0;
      r_err_cnt  <= 16'd0;
      r_good_cnt <= 16'd0;
    end else begin
      r_err <= w_err_evt;

      if (i_clr_cnt) begin
        r_err_cnt <= 16'd0;
      end else if (w_err_evt && (r_err_cnt != CNT_SAT)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end

      if (i_clr_cnt) begin
        r_good_cnt <= 16'd0;
      end else if (w_good_evt && (r_good_cnt != CNT_SAT)) begin
        r_good_cnt <= r_good_cnt + 16'd1;
      end
    end
  end

  assign o_err      = r_err;
  assign o_err_cnt  = r_err_cnt;
  assign o_good_cnt = r_good_cnt;

endmodule

// File: doc/tb_pattern_chk.md
Name: tb_pattern_chk

Overview:
- Checks the test pattern on the receive end of the SFP link.
- The expected stream is an 8-bit value that holds for 2^LSB_POS cycles, then increments modulo 256.
- The block locks onto the received stream, checks every value transition for correct value and correct run length, and detects a stuck stream.
- It reports lock status plus saturating error and good-transition counters to the testbench or a debug register block.

Parameters:
- LSB_POS, 10, log2 of the nominal run length; nominal run RUN_NOM = 2^LSB_POS cycles.
- TOL, 2, allowed run-length deviation in cycles (receive-path jitter); legal run is RUN_NOM-TOL .. RUN_NOM+TOL inclusive.
- LOCK_CNT, 4, consecutive good transitions needed in SYNC to enter LOCKED.
- UNLOCK_ERR, 4, consecutive bad events in LOCKED that force a return to HUNT.

Ports:
- i_clk, input, 1, system clock.
- i_res, input, 1, synchronous active-high reset.
- i_ptn, input, 8, received pattern, already synchronous to i_clk.
- i_clr_cnt, input, 1, synchronous clear of o_err_cnt and o_good_cnt.
- o_lock, output, 1, high while the state is LOCKED.
- o_err, output, 1, one-cycle pulse per detected error event.
- o_err_cnt, output, 16, saturating count of error events, counted in SYNC and LOCKED.
- o_good_cnt, output, 16, saturating count of good transitions, counted in SYNC and LOCKED.

Behaviour:
Reset and clock:
- Single clock; all state changes occur on the posedge of i_clk.
- i_res is synchronous active-high. It has priority over everything and may assert at any time, including mid-lock.
- Reset values: o_lock=0, o_err=0, o_err_cnt=0, o_good_cnt=0, state=HUNT, r_ptn=0, r_cur=0, r_run=1, good/bad run counters=0, stuck flag=0.

Input and run tracking:
- i_ptn is registered into r_ptn.
- A change event is r_ptn != r_cur. On a change event: r_cur<=r_ptn, r_run<=1, stuck flag cleared.
- Otherwise r_run increments. r_run is LSB_POS+2 bits wide and saturates at all-ones.
- The measured run length of the previous value is r_run at the change event. A clean generator gives exactly RUN_NOM.

Transition check (change event, outside HUNT):
- Value is good iff r_ptn == r_cur+1 mod 256; 0xFF->0x00 is good.
- Timing is good iff r_run is within the legal range. The timing check is skipped if the stuck flag is set.
- A good transition needs both checks good. Anything else is one error event; value and timing faults on the same transition count as a single event.

Stuck check (outside HUNT):
- When r_run reaches RUN_NOM+TOL+1 with no change, raise one error event and set the stuck flag.
- Only one stuck error is raised per run.

States:
- HUNT: no checks and no counting. The first change event moves to SYNC, with the good and bad run counters cleared. The run starting there is the first fully measurable one.
- SYNC: a good transition increments the good run counter; when it reaches LOCK_CNT, go to LOCKED and set o_lock=1 in the same edge. An error event clears the good run counter and stays in SYNC.
- LOCKED: a good transition clears the bad run counter. An error event increments it; when it reaches UNLOCK_ERR, go to HUNT and set o_lock=0 in the same edge.

Counters and latency:
- In SYNC and LOCKED, o_good_cnt increments per good transition and o_err_cnt per error event; both saturate at 0xFFFF.
- o_err is registered and pulses high for one cycle per error event. An erroneous value first present on i_ptn in cycle N gives o_err high in cycle N+2. Stuck error timing is equivalent, measured from the cycle r_run crosses the limit.
- i_clr_cnt sets both counters to 0 and wins over a simultaneous increment. The event still pulses o_err and still updates the state machine and its run counters.
- i_clr_cnt does not affect state or o_lock.

Test Plan:
All scenarios use LSB_POS=4 (RUN_NOM=16), TOL=1, LOCK_CNT=4, UNLOCK_ERR=4, and drive i_ptn from a counter-derived generator.
1. Reset, then clean stream starting 0x00 -> SYNC at the first change, o_lock=1 after 4 more good transitions, o_err never pulses, o_err_cnt=0, o_good_cnt=4 at lock.
2. Locked; stream skips 0x12->0x14 -> single o_err pulse two cycles after 0x14 appears, o_err_cnt=1, o_lock stays 1. The following 0x14->0x15 counts as good.
3. Locked; one run of 17 cycles -> no error. One run of 18 cycles -> o_err_cnt+1. One run of 14 cycles -> o_err_cnt+1.
4. Locked; value 0x30 held 40 cycles, then 0x31 -> exactly one error when r_run reaches 18, none at the 0x31 transition, o_err_cnt+1.
5. Locked; 4 consecutive skipped values -> o_lock=0 on the edge of the 4th error, state HUNT. Clean stream afterwards -> relock after 1+4 transitions.
6. Wrap 0xFF->0x00 is good with no error. i_clr_cnt asserted together with an error -> o_err pulses, o_err_cnt=0. i_res asserted mid-lock -> all outputs 0 on the next cycle, HUNT.
